// File: rtl/axi_ram.sv
// axi_ram: single-port, word-addressed 32-bit RAM behind a simplified
// valid/ready handshake. A small registered FSM handles three jobs:
// it acknowledges writes, returns read data as a one-beat response, and
// gives priority to a write when a write and a read arrive together.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE_WAIT | first cycle after reset; requests are ignored
// IDLE      | ready for a request (Write_Ready=1)
// WR_ACK    | write committed last edge; one dead cycle (Write_Ready=0)
// RD_DATA   | read data on Data_Out with Read_Valid=1 for this cycle
module axi_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  AXI_RAM_Clk,
  input  logic                  AXI_RAM_Reset_InLow,
  input  logic                  AXI_RAM_Read_Ready,
  input  logic                  AXI_RAM_Write_Valid,
  input  logic [ADDR_WIDTH-1:0] AXI_RAM_Address,
  input  logic [31:0]           AXI_RAM_Data_In,
  output logic                  AXI_RAM_Read_Valid,
  output logic                  AXI_RAM_Write_Ready,
  output logic [31:0]           AXI_RAM_Data_Out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE_WAIT = 2'd0,
    IDLE      = 2'd1,
    WR_ACK    = 2'd2,
    RD_DATA   = 2'd3
  } state_e;

  state_e      state_q;
  logic        wr_ready_q;
  logic        rd_valid_q;
  logic [31:0] data_out_q;
  logic        wr_en;
  logic        rd_en;

  logic [31:0] mem_q [DEPTH];

  // A request is only taken in IDLE. When both are present, the write wins,
  // and the read is served later if the master is still holding it.
  assign wr_en = (state_q == IDLE) && AXI_RAM_Write_Valid;
  assign rd_en = (state_q == IDLE) && AXI_RAM_Read_Ready && !AXI_RAM_Write_Valid;

  // Memory write port. It has no reset, so the contents survive reset and
  // the array can still map to block RAM.
  always_ff @(posedge AXI_RAM_Clk) begin
    if (wr_en) begin
      mem_q[AXI_RAM_Address] <= AXI_RAM_Data_In;
    end
  end

  // FSM with registered outputs. The read data register holds its value
  // until the next read.
  always_ff @(posedge AXI_RAM_Clk or negedge AXI_RAM_Reset_InLow) begin
    if (!AXI_RAM_Reset_InLow) begin
      state_q    <= IDLE_WAIT;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE_WAIT: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
          rd_valid_q <= 1'b0;
        end
        IDLE: begin
          if (wr_en) begin
            state_q    <= WR_ACK;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
          end else if (rd_en) begin
            state_q    <= RD_DATA;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b1;
            data_out_q <= mem_q[AXI_RAM_Address];
          end else begin
            wr_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
          end
        end
        WR_ACK: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
          rd_valid_q <= 1'b0;
        end
        RD_DATA: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
          rd_valid_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE_WAIT;
          wr_ready_q <= 1'b0;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign AXI_RAM_Write_Ready = wr_ready_q;
  assign AXI_RAM_Read_Valid  = rd_valid_q;
  assign AXI_RAM_Data_Out    = data_out_q;

endmodule

// File: tb/tb_axi_ram.sv
// Testbench for axi_ram. It applies a table of directed vectors, one row per
// clock, and then runs hand-written sequences for reset corner cases.
module tb_axi_ram;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          rd_ready;
  logic          wr_valid;
  logic [AW-1:0] addr;
  logic [31:0]   din;
  logic          rd_valid;
  logic          wr_ready;
  logic [31:0]   dout;

  int errors = 0;
  int checks = 0;

  axi_ram #(.ADDR_WIDTH(AW)) dut (
    .AXI_RAM_Clk         (clk),
    .AXI_RAM_Reset_InLow (rst_n),
    .AXI_RAM_Read_Ready  (rd_ready),
    .AXI_RAM_Write_Valid (wr_valid),
    .AXI_RAM_Address     (addr),
    .AXI_RAM_Data_In     (din),
    .AXI_RAM_Read_Valid  (rd_valid),
    .AXI_RAM_Write_Ready (wr_ready),
    .AXI_RAM_Data_Out    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic          rr;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          ewr;
    logic          erv;
    logic [31:0]   edout;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic wv, input logic rr, input logic [AW-1:0] a,
                              input logic [31:0] d, input logic ewr, input logic erv,
                              input logic [31:0] edout);
    vec_t v;
    v.wv = wv; v.rr = rr; v.a = a; v.d = d;
    v.ewr = ewr; v.erv = erv; v.edout = edout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic rr, input logic [AW-1:0] a, input logic [31:0] d);
    wr_valid = wv;
    rd_ready = rr;
    addr     = a;
    din      = d;
  endtask

  initial begin
    // Each row gives the inputs applied before an edge and the outputs
    // expected just after that edge.
    vq.push_back(mk(1'b1, 1'b0, 10'd0,    32'h00000010, 1'b0, 1'b0, 32'h00000000)); // write 0
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h00000000));
    vq.push_back(mk(1'b0, 1'b1, 10'd0,    32'h0,        1'b0, 1'b1, 32'h00000010)); // read 0
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h00000010));
    vq.push_back(mk(1'b1, 1'b0, 10'd1023, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000010)); // top addr
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h00000010));
    vq.push_back(mk(1'b1, 1'b0, 10'd0,    32'h12345678, 1'b0, 1'b0, 32'h00000010));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h00000010));
    vq.push_back(mk(1'b0, 1'b1, 10'd1023, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'hDEADBEEF));
    vq.push_back(mk(1'b0, 1'b1, 10'd0,    32'h0,        1'b0, 1'b1, 32'h12345678));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h12345678));
    vq.push_back(mk(1'b1, 1'b1, 10'd5,    32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678)); // both: write wins
    vq.push_back(mk(1'b0, 1'b1, 10'd5,    32'h0,        1'b1, 1'b0, 32'h12345678)); // WR_ACK ignores read
    vq.push_back(mk(1'b0, 1'b1, 10'd5,    32'h0,        1'b0, 1'b1, 32'hA5A5A5A5));
    vq.push_back(mk(1'b0, 1'b1, 10'd5,    32'h0,        1'b1, 1'b0, 32'hA5A5A5A5)); // drop regardless
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'hA5A5A5A5));
    vq.push_back(mk(1'b1, 1'b0, 10'd1,    32'h00000111, 1'b0, 1'b0, 32'hA5A5A5A5)); // back-to-back
    vq.push_back(mk(1'b1, 1'b0, 10'd2,    32'h00000222, 1'b1, 1'b0, 32'hA5A5A5A5));
    vq.push_back(mk(1'b1, 1'b0, 10'd2,    32'h00000222, 1'b0, 1'b0, 32'hA5A5A5A5));
    vq.push_back(mk(1'b1, 1'b0, 10'd3,    32'h00000333, 1'b1, 1'b0, 32'hA5A5A5A5));
    vq.push_back(mk(1'b1, 1'b0, 10'd3,    32'h00000333, 1'b0, 1'b0, 32'hA5A5A5A5));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'hA5A5A5A5));
    vq.push_back(mk(1'b0, 1'b1, 10'd1,    32'h0,        1'b0, 1'b1, 32'h00000111));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h00000111));
    vq.push_back(mk(1'b0, 1'b1, 10'd2,    32'h0,        1'b0, 1'b1, 32'h00000222));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h00000222));
    vq.push_back(mk(1'b0, 1'b1, 10'd3,    32'h0,        1'b0, 1'b1, 32'h00000333));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 32'h00000333));

    // Reset and the first cycle after release
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    step();
    step();
    chk("reset wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("reset rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset dout", dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-release wr_ready", {31'b0, wr_ready}, 32'd0);
    step();
    chk("idle wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("idle rd_valid", {31'b0, rd_valid}, 32'd0);

    // Table of directed vectors
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].wv, vq[i].rr, vq[i].a, vq[i].d);
      step();
      chk($sformatf("vec%0d wr_ready", i), {31'b0, wr_ready}, {31'b0, vq[i].ewr});
      chk($sformatf("vec%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, vq[i].erv});
      chk($sformatf("vec%0d dout", i), dout, vq[i].edout);
    end

    // Assert reset while a read response is on the bus
    drive(1'b0, 1'b1, 10'd1023, 32'h0);
    step();
    chk("pre-reset rd_valid", {31'b0, rd_valid}, 32'd1);
    chk("pre-reset dout", dout, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-reset rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("mid-reset dout", dout, 32'h0);
    chk("mid-reset wr_ready", {31'b0, wr_ready}, 32'd0);
    drive(1'b0, 1'b0, '0, '0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    // A write offered during IDLE_WAIT must be dropped
    drive(1'b1, 1'b0, 10'd3, 32'hBADBAD00);
    step();
    chk("wait->idle wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("wait->idle rd_valid", {31'b0, rd_valid}, 32'd0);
    drive(1'b0, 1'b1, 10'd3, 32'h0);
    step();
    chk("ignored write rd_valid", {31'b0, rd_valid}, 32'd1);
    chk("ignored write dout", dout, 32'h00000333);
    drive(1'b0, 1'b0, '0, '0);
    step();
    drive(1'b0, 1'b1, 10'd1023, 32'h0);
    step();
    chk("survive reset rd_valid", {31'b0, rd_valid}, 32'd1);
    chk("survive reset dout", dout, 32'hDEADBEEF);
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("final rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("final wr_ready", {31'b0, wr_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
